// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes,
// lane-mask lookup and access legality helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access of the given size, before offset shift.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Number of bytes moved by an access of the given size.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  // Stores accept sb/sh/sw only; loads add the unsigned byte/half forms.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: positions store data/byte enables for the
// first and second word of an access, and merges/extends load data.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [63:0] merged;

  // Shift across a two-word window; the upper half feeds the second access.
  always_comb begin
    be_wide    = {4'b0000, lane_mask(funct3[1:0])} << off;
    wdata_wide = {32'd0, wdata} << {off, 3'b000};
    merged     = {hi, lo} >> {off, 3'b000};
    be0        = be_wide[3:0];
    be1        = be_wide[7:4];
    wdata0     = wdata_wide[31:0];
    wdata1     = wdata_wide[63:32];
    rdata      = '0;
    case (funct3)
      F3_B:    rdata = {{24{merged[7]}}, merged[7:0]};
      F3_H:    rdata = {{16{merged[15]}}, merged[15:0]};
      F3_W:    rdata = merged[31:0];
      F3_BU:   rdata = {24'd0, merged[7:0]};
      F3_HU:   rdata = {16'd0, merged[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, issues one or two
// word-aligned memory accesses with byte enables and returns merged data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  lsu_state_e    state_reg, state_next;
  logic          we_reg, err_reg;
  logic [2:0]    funct3_reg;
  logic [31:0]   addr_reg, wdata_reg, lo_reg, hi_reg;
  logic [TW-1:0] tcnt_reg;

  logic          accept, req_bad, timed_out, split;
  logic [32:0]   last_byte;
  logic [2:0]    span;
  logic [3:0]    be0, be1;
  logic [31:0]   wdata0, wdata1, load_rdata;

  // Request checks; 33-bit sum so a carry out of bit 31 reads as out of range.
  always_comb begin
    accept    = (state_reg == ST_IDLE) && !rst && req_valid;
    last_byte = {1'b0, req_addr} + 33'(access_bytes(req_funct3[1:0])) - 33'd1;
    req_bad   = !funct3_legal(req_we, req_funct3) || (last_byte >= MEM_BYTES);
    span      = {1'b0, addr_reg[1:0]} + access_bytes(funct3_reg[1:0]);
    split     = span > 3'd4;
    timed_out = tcnt_reg == TW'(TIMEOUT - 1);
  end

  load_store_unit_lane_align u_align (
    .off    (addr_reg[1:0]),
    .funct3 (funct3_reg),
    .wdata  (wdata_reg),
    .lo     (lo_reg),
    .hi     (hi_reg),
    .be0    (be0),
    .be1    (be1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata  (load_rdata)
  );

  // State register, request latches, captured read words and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      funct3_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      tcnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            err_reg    <= req_bad;
            lo_reg     <= '0;
            hi_reg     <= '0;
            tcnt_reg   <= '0;
          end
        end
        ST_ACC0: begin
          if (mem_ack) begin
            lo_reg   <= mem_rdata;
            tcnt_reg <= '0;
          end else if (timed_out) begin
            err_reg <= 1'b1;
          end else begin
            tcnt_reg <= tcnt_reg + TW'(1);
          end
        end
        ST_ACC1: begin
          if (mem_ack) begin
            hi_reg <= mem_rdata;
          end else if (timed_out) begin
            err_reg <= 1'b1;
          end else begin
            tcnt_reg <= tcnt_reg + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and outputs; memory outputs depend only on state and latches
  // so they stay stable while mem_req is held.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = !rst;
        if (accept) state_next = req_bad ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_reg;
        mem_addr  = {addr_reg[31:2], 2'b00};
        mem_be    = be0;
        mem_wdata = wdata0;
        if (mem_ack)        state_next = split ? ST_ACC1 : ST_RESP;
        else if (timed_out) state_next = ST_RESP;
      end
      ST_ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_reg;
        mem_addr  = {addr_reg[31:2] + 30'd1, 2'b00};
        mem_be    = be1;
        mem_wdata = wdata1;
        if (mem_ack || timed_out) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        resp_rdata = (err_reg || we_reg) ? 32'd0 : load_rdata;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases plus randomized loads/stores checked
// against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.MEM_WORDS(256), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] dut_mem [256];
  logic [7:0]  ref_mem [1024];

  logic [31:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_wdata[$];
  int          ack_delay = 0;
  bit          ack_never = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  bit          resp_seen = 0;
  int          resp_cnt = 0;
  int          resp_cyc = 0;
  logic [31:0] resp_rd_seen = '0;
  logic        resp_err_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder and response monitor, both working at the falling edge.
  always @(negedge clk) begin
    if (mem_req && !rst) begin
      req_cycles++;
      if (!ack_never && wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = dut_mem[mem_addr[9:2]];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) dut_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        log_addr.push_back(mem_addr);
        log_be.push_back(mem_be);
        log_wdata.push_back(mem_wdata);
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (resp_valid) begin
      resp_seen     = 1;
      resp_cnt++;
      resp_cyc      = cyc;
      resp_rd_seen  = resp_rdata;
      resp_err_seen = resp_err;
    end
  end

  // Issue one request and wait (bounded) for its response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat, output bit got);
    int acc_cyc;
    int guard;
    log_addr.delete(); log_be.delete(); log_wdata.delete();
    resp_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_seen && guard < 100) begin @(posedge clk); guard++; end
    got = resp_seen;
    rd  = resp_rd_seen;
    er  = resp_err_seen;
    lat = resp_cyc - acc_cyc;
  endtask

  // Reference model works on individual bytes; expected accesses are derived
  // from which words the byte range touches.
  task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                           output logic [31:0] rd, output logic er);
    int n, first_word, k, slot, nacc, lat, cnt0;
    bit legal, exp_err, got;
    logic [31:0] exp_rd, mask, val;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    exp_err = !legal || (longint'(addr) + n - 1 >= 1024);
    exp_rd = 0; nacc = 0;
    exp_be[0] = 0; exp_be[1] = 0; exp_wd[0] = 0; exp_wd[1] = 0;
    first_word = int'(addr >> 2);
    if (!exp_err) begin
      val = 0;
      for (int i = 0; i < n; i++) begin
        k = int'(addr) + i;
        slot = (k >> 2) - first_word;
        exp_be[slot][k % 4] = 1'b1;
        exp_wd[slot][8*(k % 4) +: 8] = wdata[8*i +: 8];
        if (slot + 1 > nacc) nacc = slot + 1;
        val[8*i +: 8] = ref_mem[k];
        if (we) ref_mem[k] = wdata[8*i +: 8];
      end
      if (!we) begin
        if (!f3[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
        if (!f3[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
        exp_rd = val;
      end
    end
    ack_delay = dly;
    cnt0 = resp_cnt;
    do_req(we, f3, addr, wdata, rd, er, lat, got);
    @(negedge clk); @(negedge clk);
    chk({tag, ".resp"}, 32'(got), 32'd1);
    chk({tag, ".once"}, 32'(resp_cnt - cnt0), 32'd1);
    if (got) begin
      chk({tag, ".rdata"}, rd, exp_rd);
      chk({tag, ".err"}, 32'(er), 32'(exp_err));
      chk({tag, ".lat"}, 32'(lat), exp_err ? 32'd1 : 32'(1 + (dly + 1) * nacc));
    end
    chk({tag, ".nacc"}, 32'(log_addr.size()), 32'(nacc));
    for (int s = 0; s < nacc && s < log_addr.size(); s++) begin
      mask = {{8{exp_be[s][3]}}, {8{exp_be[s][2]}}, {8{exp_be[s][1]}}, {8{exp_be[s][0]}}};
      chk({tag, ".maddr"}, log_addr[s], 32'((first_word + s) * 4));
      chk({tag, ".mbe"}, 32'(log_be[s]), 32'(exp_be[s]));
      if (we) chk({tag, ".mwdata"}, log_wdata[s] & mask, exp_wd[s]);
    end
  endtask

  initial begin
    logic [31:0] rd, w, a;
    logic        er;
    int          lat, cnt0, sel, diffs;
    bit          got;

    for (int i = 0; i < 256; i++) begin
      w = (i == 0) ? 32'h80000001 : (i == 1) ? 32'hDDCCBBAA : (i == 2) ? 32'h11223344 : $urandom;
      dut_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.req_ready", 32'(req_ready), 32'd1);

    // Directed cases
    run_check("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er);
    chk("lw0.value", rd, 32'h80000001);
    run_check("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 0, rd, er);
    chk("lb3.value", rd, 32'hFFFFFF80);
    run_check("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 0, rd, er);
    chk("lbu3.value", rd, 32'h00000080);
    run_check("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 0, rd, er);
    chk("lhu4.value", rd, 32'h0000BBAA);
    run_check("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 0, rd, er);
    chk("lw6.value", rd, 32'h3344DDCC);
    run_check("sh3", 1'b1, 3'b001, 32'h3, 32'h0000BEEF, 0, rd, er);
    chk("sh3.rdata0", rd, 32'h0);
    if (log_addr.size() == 2) begin
      chk("sh3.be0", 32'(log_be[0]), 32'h8);
      chk("sh3.byte0", 32'(log_wdata[0][31:24]), 32'hEF);
      chk("sh3.addr1", log_addr[1], 32'h4);
      chk("sh3.be1", 32'(log_be[1]), 32'h1);
      chk("sh3.byte1", 32'(log_wdata[1][7:0]), 32'hBE);
    end else chk("sh3.access_count", 32'(log_addr.size()), 32'd2);
    run_check("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0, 0, rd, er);
    chk("lw3fe.err", 32'(er), 32'd1);
    run_check("f3_011", 1'b0, 3'b011, 32'h8, 32'h0, 0, rd, er);
    chk("f3_011.err", 32'(er), 32'd1);
    run_check("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 0, rd, er);
    run_check("wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0, rd, er);

    // Randomized loads/stores with random ack wait states
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 63));
      else if (sel < 9) a = 32'($urandom_range(1016, 1023));
      else              a = $urandom;
      run_check($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                a, $urandom, $urandom_range(0, 2), rd, er);
    end

    // Memory never acknowledges: mem_req for exactly TIMEOUT cycles then error
    ack_never = 1; req_cycles = 0;
    do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, got);
    chk("tmo.resp", 32'(got), 32'd1);
    chk("tmo.err", 32'(er), 32'd1);
    chk("tmo.rdata", rd, 32'h0);
    chk("tmo.req_cycles", 32'(req_cycles), 32'd16);
    ack_never = 0;

    // Reset while the second half of a split access is outstanding
    ack_delay = 0; cnt0 = resp_cnt;
    log_addr.delete(); log_be.delete(); log_wdata.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    ack_never = 1;
    @(negedge clk);
    chk("rstmid.acc1_req", 32'(mem_req), 32'd1);
    chk("rstmid.acc1_addr", mem_addr, 32'h8);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk("rstmid.ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    ack_never = 0;
    @(negedge clk);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rstmid.no_resp", 32'(resp_cnt - cnt0), 32'd0);

    // Final memory image must match the reference byte array
    diffs = 0;
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 4; b++)
        if (dut_mem[i][8*b +: 8] !== ref_mem[4*i + b]) diffs++;
    chk("mem_image.diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
